// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_WIDTH      = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Big-endian 8->32 assembler: first byte of a word lands in [31:24].
// word_valid is combinational on the 4th byte so the loader can register the write.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    assign o_word_valid = i_byte_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));
    assign o_word       = {r_shift, i_byte};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_byte_valid) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory; releases the core
// (cpu_run) only after a load whose length and XOR checksum are valid.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [31:0]           imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_run,
    output logic                  busy,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [7:0]             r_len_hi;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_word_idx;
    logic [7:0]             r_xor;
    logic                   r_we;
    logic [31:0]            r_addr;
    logic [31:0]            r_wdata;
    logic [ADDR_WIDTH:0]    r_words_loaded;

    logic                   w_fire;
    logic                   w_start_ok;
    logic                   w_byte_data;
    logic [LEN_WIDTH-1:0]   w_len_next;
    logic                   w_oversize;
    logic                   w_last_word;
    logic                   w_word_valid;
    logic [31:0]            w_word;

    assign w_fire      = in_valid && in_ready;
    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                   (r_state == ST_ERROR));
    assign w_byte_data = w_fire && (r_state == ST_DATA);
    assign w_len_next  = {r_len_hi, in_data};
    assign w_oversize  = 32'(w_len_next) > MAX_WORDS;
    assign w_last_word = (r_word_idx == (r_len - LEN_WIDTH'(1)));

    word_assembler u_asm (
        .clk          (clk),
        .rst_n        (reset),
        .i_clear      (w_start_ok),
        .i_byte_valid (w_byte_data),
        .i_byte       (in_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_next = ST_LEN_HI;
            ST_LEN_HI: if (w_fire) w_state_next = ST_LEN_LO;
            ST_LEN_LO: begin
                if (w_fire) begin
                    if (w_oversize)             w_state_next = ST_ERROR;
                    else if (w_len_next == '0)  w_state_next = ST_CHECK;
                    else                        w_state_next = ST_DATA;
                end
            end
            ST_DATA:   if (w_word_valid && w_last_word) w_state_next = ST_CHECK;
            ST_CHECK:  if (w_fire) w_state_next = (in_data == r_xor) ? ST_DONE : ST_ERROR;
            ST_DONE,
            ST_ERROR:  if (start) w_state_next = ST_LEN_HI;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        cpu_run  = 1'b0;
        load_err = 1'b0;
        case (r_state)
            ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_DONE:  cpu_run  = 1'b1;
            ST_ERROR: load_err = 1'b1;
            default:  ;
        endcase
    end

    // Write strobe and count move together; a byte may be accepted while r_we is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len_hi       <= '0;
            r_len          <= '0;
            r_word_idx     <= '0;
            r_xor          <= '0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_words_loaded <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_start_ok) begin
                r_len          <= '0;
                r_word_idx     <= '0;
                r_xor          <= '0;
                r_words_loaded <= '0;
            end
            if (w_fire && (r_state == ST_LEN_HI)) r_len_hi <= in_data;
            if (w_fire && (r_state == ST_LEN_LO)) r_len    <= w_len_next;
            if (w_byte_data) r_xor <= r_xor ^ in_data;
            if (w_word_valid) begin
                r_we           <= 1'b1;
                r_wdata        <= w_word;
                r_addr         <= BASE_ADDR + (32'(r_word_idx) << 2);
                r_word_idx     <= r_word_idx + LEN_WIDTH'(1);
                r_words_loaded <= r_words_loaded + (ADDR_WIDTH + 1)'(1);
            end
        end
    end

    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: frames are modelled as word lists, expected
// writes are queued at stimulus time and matched by an independent write monitor.
module tb_imem_loader;

    localparam int unsigned AW   = 8;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_run;
    logic        busy;
    logic        load_err;
    logic [AW:0] words_loaded;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_run      (cpu_run),
        .busy         (busy),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    logic [31:0] fixed_words[$];
    bit          gap_mode = 1'b0;
    int          cyc = 0;
    int          last_we = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (reset && imem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", {32'h0, imem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {32'h0, imem_addr}, {32'h0, e[63:32]});
                check("wr_data", {32'h0, imem_wdata}, {32'h0, e[31:0]});
            end
            if (gap_mode && last_we >= 0) check("wr_gap", 64'(cyc - last_we), 64'd4);
            last_we = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("in_ready_timeout", {63'h0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Reference: a frame is N words sent MSB-first; checksum is XOR of every payload byte.
    task automatic run_frame(input int n, input logic [7:0] mask, input bit stream, input bit poke);
        logic [7:0]  x;
        logic [31:0] w;
        logic [15:0] len;
        logic [7:0]  pl[$];
        x   = 8'h00;
        len = 16'(n);
        for (int i = 0; i < n; i++) begin
            if (fixed_words.size() != 0) w = fixed_words.pop_front();
            else                         w = $urandom;
            exp_q.push_back({BASE + 32'(i) * 32'd4, w});
            for (int b = 0; b < 4; b++) begin
                pl.push_back(8'(w >> (24 - 8 * b)));
                x = x ^ 8'(w >> (24 - 8 * b));
            end
        end
        pulse_start();
        check("start_clears", {60'h0, cpu_run, load_err, busy, (words_loaded == '0)}, 64'b0011);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        if (poke) pulse_start();
        last_we  = -1;
        gap_mode = stream;
        foreach (pl[i]) begin
            if (!stream && $urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
            send_byte(pl[i]);
        end
        send_byte(x ^ mask);
        gap_mode = 1'b0;
        check("cpu_run", {63'h0, cpu_run}, {63'h0, (mask == 8'h00)});
        check("load_err", {63'h0, load_err}, {63'h0, (mask != 8'h00)});
        check("words_loaded", 64'(words_loaded), 64'(n));
        check("busy_after", {63'h0, busy}, 64'd0);
        check("pending_writes", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        tick(2);
        check("rst_ctrl", 64'({in_ready, imem_we, cpu_run, busy, load_err, words_loaded}), 64'd0);
        check("rst_data", {imem_addr, imem_wdata}, 64'd0);
        reset = 1'b1;
        tick(2);

        // Basic load: 00 01 20 08 00 05, checksum 2D
        fixed_words.push_back(32'h2008_0005);
        run_frame(1, 8'h00, 1'b0, 1'b0);
        // Same word, checksum 2C
        fixed_words.push_back(32'h2008_0005);
        run_frame(1, 8'h01, 1'b0, 1'b0);

        // Oversize: N = 0x0101 with 2^8 capacity
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        tick(3);
        check("oversize_err", 64'({load_err, in_ready, busy, cpu_run, words_loaded}), 64'({1'b1, 3'b000, (AW + 1)'(0)}));

        run_frame(0, 8'h00, 1'b0, 1'b0);
        run_frame(3, 8'h00, 1'b1, 1'b0);
        run_frame(2, 8'h00, 1'b0, 1'b1);
        run_frame(256, 8'h00, 1'b1, 1'b0);

        // Reset mid-DATA: one word written, then reset partway through the second
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        exp_q.push_back({BASE, 32'hDEAD_BEEF});
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'h11); send_byte(8'h22);
        #3;
        reset = 1'b0;
        #1;
        check("midrst_ctrl", 64'({in_ready, imem_we, cpu_run, busy, load_err, words_loaded}), 64'd0);
        check("midrst_data", {imem_addr, imem_wdata}, 64'd0);
        check("midrst_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        tick(2);
        reset = 1'b1;
        tick(1);
        check("after_rst_idle", 64'({in_ready, busy, cpu_run, load_err}), 64'd0);
        run_frame(2, 8'h00, 1'b0, 1'b0);

        for (int f = 0; f < 30; f++) begin
            run_frame($urandom_range(0, 6),
                      ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 4));
        end

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the single-cycle core fetches from.
- Accepts a framed byte stream on a valid/ready interface and assembles the bytes big-endian into 32-bit words.
- Writes the words to consecutive word-aligned instruction memory addresses and checks an XOR checksum.
- Holds the core out of execution (cpu_run=0) until a load completes cleanly.

Parameters:
- ADDR_WIDTH, 8, word-address width; capacity 2^ADDR_WIDTH words.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written (word-aligned).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR
- in_valid  input  1  byte on in_data is valid
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle
- imem_we  output  1  instruction memory write strobe, one cycle per word
- imem_addr  output  32  byte address of the write, word-aligned
- imem_wdata  output  32  word to write
- cpu_run  output  1  1 = core may execute; drive to core reset release
- busy  output  1  load in progress
- load_err  output  1  sticky error flag for the last load
- words_loaded  output  ADDR_WIDTH+1  count of words written in the current/last load

Behaviour:
- Reset (reset=0, async): state IDLE; every output 0; internal length, checksum and byte counters cleared. Memory contents are untouched; words already written by an interrupted load remain.
- Frame format: LEN_HI, LEN_LO (N, 16-bit, big-endian), then 4*N payload bytes, then 1 checksum byte equal to the XOR of all payload bytes.
- Handshake: a byte transfers on a rising edge with in_valid && in_ready. in_ready=1 in LEN_HI, LEN_LO, DATA and CHECK; 0 elsewhere. No backpressure inside a frame.
- FSM transitions:
  - IDLE -> LEN_HI on start.
  - LEN_HI -> LEN_LO on byte.
  - LEN_LO -> on byte: if N > 2^ADDR_WIDTH go to ERROR with no writes; if N=0 go to CHECK; else go to DATA.
  - DATA: shift bytes into wdata (first byte to [31:24]). On the 4th byte of a word, register imem_wdata and imem_addr = BASE_ADDR + 4*word_idx, assert imem_we the next cycle for exactly one cycle, and increment words_loaded with that strobe. After word N go to CHECK.
  - CHECK -> on byte: DONE if it equals the running XOR, else ERROR.
  - DONE and ERROR -> LEN_HI on start.
- busy=1 in LEN_HI..CHECK. On start, load_err and words_loaded clear and cpu_run drops the same edge. start while busy is ignored.
- cpu_run=1 only in DONE. load_err=1 only in ERROR.
- Running XOR covers payload bytes only and resets to 0 on start.
- A byte accepted in the cycle imem_we is high is processed normally; back-to-back words at one byte per cycle must be supported.
- Address arithmetic is 32-bit. word_idx never exceeds N-1, so no wrap.

Decomposition:
- Shared package (imem_loader_pkg):
  - state encoding localparams (IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR);
  - BYTES_PER_WORD=4;
  - LEN_WIDTH=16.
- One natural sub-module, word_assembler:
  - 8->32 shift register and 2-bit byte counter;
  - emits word_valid with the assembled word;
  - FSM, address counter and checksum stay in imem_loader.

Test Plan:
- Basic load:
  - Stimulus: start; bytes 00 01 20 08 00 05 2D.
  - Response: one imem_we with addr 0x0, wdata 0x20080005; then DONE, cpu_run=1, words_loaded=1, load_err=0.
- Bad checksum:
  - Stimulus: same frame with checksum 0x2C.
  - Response: the word is still written, then ERROR; load_err=1, cpu_run=0.
- Oversize length:
  - Stimulus: ADDR_WIDTH=8, N=0x0101.
  - Response: ERROR after LEN_LO, zero imem_we pulses, in_ready=0 afterwards.
- Empty frame and streaming:
  - N=0 with checksum 00 goes to DONE, words_loaded=0.
  - N=3 streamed one byte per cycle gives writes at 0x0/0x4/0x8 four cycles apart, with no byte dropped.
- Reset and restart:
  - reset=0 asserted mid-DATA: all outputs 0 immediately, state IDLE.
  - A subsequent start with a valid frame completes normally. start pulsed while busy has no effect.
